// File: rtl/ws2812_pkg.sv
// ============================================================================
// Module : ws2812_pkg
// Brief  : State encoding, default timing, LED count and colour byte offsets
//          shared by the WS2812 strip driver files.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BIT_HIGH = 2'd1,
    ST_BIT_LOW  = 2'd2,
    ST_LATCH    = 2'd3
  } state_t;

  localparam int unsigned c_N_LEDS_DEF  = 11;
  localparam int unsigned c_MAX_LEDS    = 11;
  localparam int unsigned c_BIT_CYC_DEF = 63;
  localparam int unsigned c_T0H_CYC_DEF = 20;
  localparam int unsigned c_T1H_CYC_DEF = 40;
  localparam int unsigned c_RES_CYC_DEF = 4000;
  localparam int unsigned c_COLOR_W     = 24;

  localparam int unsigned c_R_LSB = 16;
  localparam int unsigned c_G_LSB = 8;
  localparam int unsigned c_B_LSB = 0;

  // The strip expects G, R, B on the wire, MSB first.
  function automatic logic [23:0] grb_order(input logic [23:0] rgb);
    return {rgb[c_G_LSB +: 8], rgb[c_R_LSB +: 8], rgb[c_B_LSB +: 8]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ws2812_strip_driver_if.sv
// ============================================================================
// Module : ws2812_strip_driver_if
// Brief  : Frame request, colour inputs and strip output of the WS2812 driver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ws2812_strip_driver_if;

  logic        start;
  logic [23:0] led0;
  logic [23:0] led1;
  logic [23:0] led2;
  logic [23:0] led3;
  logic [23:0] led4;
  logic [23:0] led5;
  logic [23:0] led6;
  logic [23:0] led7;
  logic [23:0] led8;
  logic [23:0] led9;
  logic [23:0] led10;
  logic        dout;
  logic        busy;
  logic        done;

  modport master (
    output start, led0, led1, led2, led3, led4, led5, led6, led7, led8, led9, led10,
    input  dout, busy, done
  );

  modport slave (
    input  start, led0, led1, led2, led3, led4, led5, led6, led7, led8, led9, led10,
    output dout, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/ws2812_bit_encoder.sv
// ============================================================================
// Module : ws2812_bit_encoder
// Brief  : Produces one WS2812 bit waveform (high T0H/T1H, low for the rest
//          of BIT_CYC) per go pulse; go may be re-issued on the bit_done cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ws2812_bit_encoder #(
  parameter int unsigned BIT_CYC = 63,
  parameter int unsigned T0H_CYC = 20,
  parameter int unsigned T1H_CYC = 40
) (
  input  wire logic clock,
  input  wire logic reset_n,
  input  wire logic i_bit,
  input  wire logic i_go,
  output logic      o_dout,
  output logic      o_high_end,
  output logic      o_bit_done
);

  localparam int unsigned c_CW = $clog2(BIT_CYC + 1);

  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] r_high_last;
  logic            r_active;
  logic            r_dout;

  assign o_dout     = r_dout;
  assign o_high_end = r_active && r_dout && (r_cnt == r_high_last);
  assign o_bit_done = r_active && (r_cnt == c_CW'(BIT_CYC - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_high_last <= '0;
      r_active    <= 1'b0;
      r_dout      <= 1'b0;
    end else if (i_go) begin
      r_cnt       <= '0;
      r_high_last <= i_bit ? c_CW'(T1H_CYC - 1) : c_CW'(T0H_CYC - 1);
      r_active    <= 1'b1;
      r_dout      <= 1'b1;
    end else if (r_active) begin
      if (o_bit_done) begin
        r_active <= 1'b0;
      end else begin
        r_cnt <= r_cnt + c_CW'(1);
      end
      if (o_high_end) begin
        r_dout <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ws2812_strip_driver.sv
// ============================================================================
// Module : ws2812_strip_driver
// Brief  : Serialises a snapshot of N_LEDS colours to a WS2812 strip, then
//          holds the latch low time. Option macro: WS2812_AUTO_REFRESH_EN
//          (restart a fresh snapshot after every latch without a start pulse).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ws2812_strip_driver
  import ws2812_pkg::*;
#(
  parameter int unsigned N_LEDS  = c_N_LEDS_DEF,
  parameter int unsigned BIT_CYC = c_BIT_CYC_DEF,
  parameter int unsigned T0H_CYC = c_T0H_CYC_DEF,
  parameter int unsigned T1H_CYC = c_T1H_CYC_DEF,
  parameter int unsigned RES_CYC = c_RES_CYC_DEF
) (
  input  wire logic             clock,
  input  wire logic             reset_n,
  ws2812_strip_driver_if.slave  io_strip
);

  localparam int unsigned c_NBITS = N_LEDS * c_COLOR_W;
  localparam int unsigned c_BW    = $clog2(c_NBITS);
  localparam int unsigned c_LW    = $clog2(RES_CYC + 1);

  if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC)) begin : g_bad_timing
    $error("ws2812_strip_driver: need 0 < T0H_CYC < T1H_CYC < BIT_CYC");
  end
  if (N_LEDS < 1 || N_LEDS > c_MAX_LEDS || RES_CYC < 1) begin : g_bad_size
    $error("ws2812_strip_driver: N_LEDS must be 1..11 and RES_CYC >= 1");
  end

  state_t             r_state;
  logic [c_NBITS-1:0] r_frame;
  logic [c_BW-1:0]    r_bit_cnt;
  logic [c_LW-1:0]    r_lat_cnt;
  logic               r_busy;
  logic               r_done;

  logic [23:0]        w_led [c_MAX_LEDS];
  logic [c_NBITS-1:0] w_load_vec;
  logic               w_start_ok;
  logic               w_lat_end;
  logic               w_last_bit;
  logic               w_load;
  logic               w_next;
  logic               w_go;
  logic               w_go_bit;
  logic               w_enc_dout;
  logic               w_high_end;
  logic               w_bit_done;

  assign w_led[0]  = io_strip.led0;
  assign w_led[1]  = io_strip.led1;
  assign w_led[2]  = io_strip.led2;
  assign w_led[3]  = io_strip.led3;
  assign w_led[4]  = io_strip.led4;
  assign w_led[5]  = io_strip.led5;
  assign w_led[6]  = io_strip.led6;
  assign w_led[7]  = io_strip.led7;
  assign w_led[8]  = io_strip.led8;
  assign w_led[9]  = io_strip.led9;
  assign w_led[10] = io_strip.led10;

  // Frame laid out in wire order: MSB is LED0's green MSB, sent first.
  always_comb begin
    w_load_vec = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      w_load_vec[(N_LEDS - 1 - i) * c_COLOR_W +: c_COLOR_W] = grb_order(w_led[i]);
    end
  end

  // A start seen on the done cycle is dropped as well, so no request queues.
  assign w_start_ok = (r_state == ST_IDLE) && io_strip.start && !r_done;
  assign w_lat_end  = (r_state == ST_LATCH) && (r_lat_cnt == c_LW'(RES_CYC - 1));
  assign w_last_bit = (r_bit_cnt == c_BW'(c_NBITS - 1));
`ifdef WS2812_AUTO_REFRESH_EN
  assign w_load     = w_start_ok || w_lat_end;
`else
  assign w_load     = w_start_ok;
`endif
  assign w_next     = (r_state == ST_BIT_LOW) && w_bit_done && !w_last_bit;
  assign w_go       = w_load || w_next;
  assign w_go_bit   = w_load ? w_load_vec[c_NBITS-1] : r_frame[c_NBITS-1];

  ws2812_bit_encoder #(
    .BIT_CYC (BIT_CYC),
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC)
  ) u_bit_encoder (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_bit      (w_go_bit),
    .i_go       (w_go),
    .o_dout     (w_enc_dout),
    .o_high_end (w_high_end),
    .o_bit_done (w_bit_done)
  );

  // r_frame always holds the next bit to send in its MSB.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_frame   <= '0;
      r_bit_cnt <= '0;
      r_lat_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_frame   <= {w_load_vec[c_NBITS-2:0], 1'b0};
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_BIT_HIGH;
          end
        end
        ST_BIT_HIGH: begin
          if (w_high_end) begin
            r_state <= ST_BIT_LOW;
          end
        end
        ST_BIT_LOW: begin
          if (w_bit_done) begin
            if (w_last_bit) begin
              r_lat_cnt <= '0;
              r_state   <= ST_LATCH;
            end else begin
              r_frame   <= {r_frame[c_NBITS-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + c_BW'(1);
              r_state   <= ST_BIT_HIGH;
            end
          end
        end
        ST_LATCH: begin
          if (w_lat_end) begin
            r_done <= 1'b1;
`ifdef WS2812_AUTO_REFRESH_EN
            r_frame   <= {w_load_vec[c_NBITS-2:0], 1'b0};
            r_bit_cnt <= '0;
            r_state   <= ST_BIT_HIGH;
`else
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
`endif
          end else begin
            r_lat_cnt <= r_lat_cnt + c_LW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_strip.dout = w_enc_dout;
  assign io_strip.busy = r_busy;
  assign io_strip.done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ws2812_strip_driver.sv
// ============================================================================
// Module : tb_ws2812_strip_driver
// Brief  : Randomised self-checking bench; expected waveforms come from the
//          colour/bit-order rules, rebuilt per bit from a frame snapshot.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ws2812_strip_driver;

  localparam int c_N    = 11;
  localparam int c_BIT  = 10;
  localparam int c_T0H  = 3;
  localparam int c_T1H  = 6;
  localparam int c_RES  = 20;
  localparam int c_NB   = c_N * 24;
  localparam int c_FRM  = c_NB * c_BIT + c_RES;
`ifdef WS2812_AUTO_REFRESH_EN
  localparam logic c_BUSY_AFTER = 1'b1;
`else
  localparam logic c_BUSY_AFTER = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_drv = 1'b0;
  logic [23:0] led_drv [c_N];
  logic [23:0] snap [c_N];
  int          n_checks = 0;
  int          n_errors = 0;

  ws2812_strip_driver_if bus ();

  assign bus.start = start_drv;
  assign bus.led0  = led_drv[0];
  assign bus.led1  = led_drv[1];
  assign bus.led2  = led_drv[2];
  assign bus.led3  = led_drv[3];
  assign bus.led4  = led_drv[4];
  assign bus.led5  = led_drv[5];
  assign bus.led6  = led_drv[6];
  assign bus.led7  = led_drv[7];
  assign bus.led8  = led_drv[8];
  assign bus.led9  = led_drv[9];
  assign bus.led10 = led_drv[10];

  ws2812_strip_driver #(
    .N_LEDS  (c_N),
    .BIT_CYC (c_BIT),
    .T0H_CYC (c_T0H),
    .T1H_CYC (c_T1H),
    .RES_CYC (c_RES)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .io_strip (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit i of the frame: LED i/24, byte order G,R,B, each byte MSB first.
  function automatic logic exp_bit(input int i);
    logic [23:0] col;
    logic [7:0]  byt;
    int          j;
    col = snap[i / 24];
    j   = i % 24;
    case (j / 8)
      0:       byt = col[15:8];
      1:       byt = col[23:16];
      default: byt = col[7:0];
    endcase
    return byt[7 - (j % 8)];
  endfunction

  function automatic logic [9:0] exp_wave(input logic b);
    logic [9:0] v;
    int         th;
    th = b ? c_T1H : c_T0H;
    v  = '0;
    for (int p = 0; p < c_BIT; p++) v[9 - p] = (p < th);
    return v;
  endfunction

  task automatic randomize_leds();
    for (int i = 0; i < c_N; i++) led_drv[i] = 24'($urandom);
  endtask

  task automatic do_start();
    repeat (2) @(negedge clock);
    start_drv = 1'b1;
    @(posedge clock);
    #1;
    start_drv = 1'b0;
  endtask

  // Called at cycle 0 of a frame (1 time unit after the accepting edge).
  task automatic run_frame(input string tag, input int evt_cycle);
    logic [9:0] obs_w;
    int         c;
    int         busy_cnt;
    int         done_cnt;
    int         lat_hi;
    snap     = led_drv;
    busy_cnt = 0;
    done_cnt = 0;
    lat_hi   = 0;
    for (int b = 0; b < c_NB; b++) begin
      obs_w = '0;
      for (int p = 0; p < c_BIT; p++) begin
        c = b * c_BIT + p;
        obs_w[9 - p] = bus.dout;
        busy_cnt += int'(bus.busy);
        if (c != 0) done_cnt += int'(bus.done);
        if (c == evt_cycle) begin
          start_drv  = 1'b1;
          led_drv[0] = ~snap[0];
        end else if (c == evt_cycle + 1) begin
          start_drv = 1'b0;
        end
        @(posedge clock);
        #1;
      end
      check_eq($sformatf("%s bit%0d", tag, b), 32'(obs_w), 32'(exp_wave(exp_bit(b))));
    end
    for (int p = 0; p < c_RES; p++) begin
      lat_hi   += int'(bus.dout);
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
      @(posedge clock);
      #1;
    end
    check_eq({tag, " latch_high_cycles"}, 32'(lat_hi), 32'd0);
    check_eq({tag, " busy_cycles"}, 32'(busy_cnt), 32'(c_FRM));
    check_eq({tag, " early_done"}, 32'(done_cnt), 32'd0);
    check_eq({tag, " done_at_end"}, 32'(bus.done), 32'd1);
    check_eq({tag, " busy_at_end"}, 32'(bus.busy), 32'(c_BUSY_AFTER));
  endtask

  initial begin
    for (int i = 0; i < c_N; i++) led_drv[i] = '0;
    #3;
    check_eq("reset dout", 32'(bus.dout), 32'd0);
    check_eq("reset busy", 32'(bus.busy), 32'd0);
    check_eq("reset done", 32'(bus.done), 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

`ifdef WS2812_AUTO_REFRESH_EN
    randomize_leds();
    do_start();
    run_frame("auto0", 150);
    randomize_leds();
    run_frame("auto1", -1);
    randomize_leds();
    run_frame("auto2", -1);
`else
    // All-black frame: every bit is a short pulse.
    do_start();
    run_frame("zeros", -1);

    for (int i = 0; i < c_N; i++) led_drv[i] = '0;
    led_drv[0] = 24'hFF0000;
    do_start();
    run_frame("red0", -1);

    randomize_leds();
    led_drv[10] = 24'h0000A5;
    do_start();
    run_frame("blue10", -1);

    for (int k = 0; k < 2; k++) begin
      randomize_leds();
      do_start();
      run_frame($sformatf("rand%0d", k), -1);
    end

    // Restart request and colour change mid-frame must not disturb it.
    randomize_leds();
    do_start();
    run_frame("midchg", 100);

    // Asynchronous reset during a high phase (cycle 500 = bit 50, phase 0).
    randomize_leds();
    do_start();
    repeat (500) begin
      @(posedge clock);
      #1;
    end
    check_eq("pre_reset dout", 32'(bus.dout), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_reset dout", 32'(bus.dout), 32'd0);
    check_eq("async_reset busy", 32'(bus.busy), 32'd0);
    begin
      int dn;
      dn = 0;
      repeat (30) begin
        @(posedge clock);
        #1;
        dn += int'(bus.done);
      end
      check_eq("reset no_done", 32'(dn), 32'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    randomize_leds();
    do_start();
    run_frame("after_reset", -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
